coin_acceptor: RTL
==================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 4, the number of consecutive sampled cycles a coin line must be stable (legal range 2..255).
REQ-002 clock  input  1  the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 coinFiveRaw  input  1  raw 5-kurus sensor line, asynchronous, may bounce.
REQ-005 coinTenRaw  input  1  raw 10-kurus sensor line, asynchronous, may bounce.
REQ-006 coinTwentyFiveRaw  input  1  raw 25-kurus sensor line, asynchronous, may bounce.
REQ-007 theProduct  input  1  product-dispense indication from the downstream vending Moore machine; 1 = dispensing, coins refused.
REQ-008 fiveKurus  output  1  one-cycle pulse per accepted 5-kurus coin, to the vending machine.
REQ-009 tenKurus  output  1  one-cycle pulse per accepted 10-kurus coin.
REQ-010 twentyFiveKurus  output  1  one-cycle pulse per accepted 25-kurus coin.
REQ-011 coinReject  output  1  high while a coin is being refused/returned.

Function
REQ-012 Each raw line SHALL pass through a two-flop synchronizer; only synchronized values (s5, s10, s25) drive the FSM.
REQ-013 FSM states SHALL be IDLE, QUALIFY, EMIT, REJECT, WAIT_RELEASE; an 8-bit stability counter cnt and a latched coin type SHALL accompany it.
REQ-014 IDLE: exactly one sync line high -> QUALIFY, latch type, cnt=1; two or more high -> REJECT, cnt=0; none high -> stay.
REQ-015 QUALIFY: latched line alone high and cnt==DEBOUNCE_CYCLES-1 -> EMIT; latched line alone high otherwise -> cnt+1; latched line low and others low -> IDLE, no output; any other line high -> REJECT, cnt=0.
REQ-016 EMIT lasts exactly one cycle; if theProduct==0 the output matching the latched type SHALL be 1 for that cycle; if theProduct==1 no coin output SHALL assert and coinReject SHALL be 1 instead; next state WAIT_RELEASE, cnt=0.
REQ-017 REJECT: coinReject=1 every cycle in state; all sync lines low -> cnt+1, else cnt=0; cnt reaching DEBOUNCE_CYCLES-1 with lines low -> IDLE.
REQ-018 WAIT_RELEASE: all sync lines low -> cnt+1, else cnt=0; cnt reaching DEBOUNCE_CYCLES-1 with lines low -> IDLE; no output asserted.
REQ-019 All outputs SHALL be decoded from registered state only (Moore); at most one of fiveKurus/tenKurus/twentyFiveKurus/coinReject-from-EMIT SHALL be high in any cycle.
REQ-020 Latency: raw line rising before edge k and held SHALL produce its pulse in the cycle following edge k+DEBOUNCE_CYCLES+1.
REQ-021 A held coin SHALL yield exactly one pulse regardless of hold duration; a bounce shorter than DEBOUNCE_CYCLES sampled cycles SHALL yield none.
REQ-022 cnt SHALL saturate, never wrap.

Reset
REQ-023 reset=1 at an edge SHALL set synchronizer flops to 0, cnt to 0, latched type to NONE, state to WAIT_RELEASE; all outputs SHALL be 0 the following cycle.
REQ-024 Reset mid-QUALIFY or mid-EMIT SHALL discard the coin; a line held across reset SHALL not be counted until released for DEBOUNCE_CYCLES cycles.

Structure
REQ-025 Shared package vending_pkg SHALL hold coin_t enum (NONE, FIVE, TEN, TWENTYFIVE), the acceptor state enum, and DEFAULT_DEBOUNCE=4.
REQ-026 One sub-module coin_sync (3-bit two-flop synchronizer, synchronous reset) SHALL be instantiated once.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset 2 cycles, release, all raw low 4 cycles -> FSM in IDLE, all outputs 0 throughout.
REQ-028 coinTenRaw high 10 cycles from edge k -> tenKurus=1 exactly one cycle, after edge k+5; no other output.
REQ-029 coinFiveRaw high 2 cycles, low, high 2 cycles (bounce) -> no pulse; then held 6 cycles -> one fiveKurus pulse.
REQ-030 coinFiveRaw and coinTwentyFiveRaw high together 5 cycles -> coinReject high from REJECT entry until 4 low cycles; no coin pulse.
REQ-031 theProduct=1 during EMIT of a 25-kurus coin -> twentyFiveKurus stays 0, coinReject=1 one cycle.
REQ-032 reset asserted during QUALIFY with coinTenRaw held 8 more cycles -> no tenKurus pulse until line released and reinserted.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types for the vending front end: coin identities, acceptor FSM states
// and the default debounce length.
package vending_pkg;

  typedef enum logic [1:0] {
    NONE,
    FIVE,
    TEN,
    TWENTYFIVE
  } coin_t;

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    EMIT,
    REJECT,
    WAIT_RELEASE
  } acc_state_t;

  localparam int DEFAULT_DEBOUNCE = 4;

endpackage

// File: rtl/coin_sync.sv
// Three-line two-flop synchronizer for the asynchronous coin sensors.
module coin_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] raw,
  output logic [2:0] sync
);

  logic [2:0] sync_p0;
  logic [2:0] sync_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 3'b000;
      sync_p1 <= 3'b000;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  assign sync = sync_p1;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces three coin sensor lines and emits
// one pulse per qualified coin, refusing coins while a product is dispensing.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clock,
  input  logic reset,
  input  logic coinFiveRaw,
  input  logic coinTenRaw,
  input  logic coinTwentyFiveRaw,
  input  logic theProduct,
  output logic fiveKurus,
  output logic tenKurus,
  output logic twentyFiveKurus,
  output logic coinReject
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [2:0] sync;
  acc_state_t state;
  acc_state_t state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  coin_t      coin;
  coin_t      coin_nxt;
  logic       one_hot;
  logic       emit_ok;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    r = (v == 8'hFF) ? v : v + 8'd1;
    return r;
  endfunction

  function automatic logic [2:0] coin_mask(input coin_t c);
    logic [2:0] m;
    case (c)
      FIVE:       m = 3'b001;
      TEN:        m = 3'b010;
      TWENTYFIVE: m = 3'b100;
      default:    m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic coin_t coin_of(input logic [2:0] s);
    coin_t c;
    case (s)
      3'b001:  c = FIVE;
      3'b010:  c = TEN;
      3'b100:  c = TWENTYFIVE;
      default: c = NONE;
    endcase
    return c;
  endfunction

  coin_sync u_sync (
    .clock (clock),
    .reset (reset),
    .raw   ({coinTwentyFiveRaw, coinTenRaw, coinFiveRaw}),
    .sync  (sync)
  );

  assign one_hot = (sync != 3'b000) && ((sync & (sync - 3'd1)) == 3'b000);

  // Reset parks in WAIT_RELEASE so a coin held across reset must be released first
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT_RELEASE;
      cnt   <= 8'd0;
      coin  <= NONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      coin  <= coin_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    coin_nxt  = coin;
    case (state)
      IDLE: begin
        if (one_hot) begin
          state_nxt = QUALIFY;
          coin_nxt  = coin_of(sync);
          cnt_nxt   = 8'd1;
        end else if (sync != 3'b000) begin
          state_nxt = REJECT;
          cnt_nxt   = 8'd0;
        end
      end
      QUALIFY: begin
        if (sync == coin_mask(coin)) begin
          if (cnt == CNT_LAST) begin
            state_nxt = EMIT;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end else if (sync == 3'b000) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
          coin_nxt  = NONE;
        end else begin
          state_nxt = REJECT;
          cnt_nxt   = 8'd0;
        end
      end
      EMIT: begin
        state_nxt = WAIT_RELEASE;
        cnt_nxt   = 8'd0;
      end
      REJECT, WAIT_RELEASE: begin
        // Both wait for all lines to stay low for the full debounce window
        if (sync == 3'b000) begin
          if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            coin_nxt  = NONE;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end else begin
          cnt_nxt = 8'd0;
        end
      end
      default: begin
        state_nxt = WAIT_RELEASE;
        cnt_nxt   = 8'd0;
        coin_nxt  = NONE;
      end
    endcase
  end

  assign emit_ok         = (state == EMIT) && !theProduct;
  assign fiveKurus       = emit_ok && (coin == FIVE);
  assign tenKurus        = emit_ok && (coin == TEN);
  assign twentyFiveKurus = emit_ok && (coin == TWENTYFIVE);
  assign coinReject      = (state == REJECT) || ((state == EMIT) && theProduct);

endmodule
